// File: rtl/particle_raster.sv
// Purpose: snapshots three particle positions per frame tick and streams a 16x16 on/off grid, row-major.
// Latency: frame_tick at edge T -> first pixel valid at T+2, one pixel per accepted beat, frame_done after the last.
// Backpressure: valid/ready; pixel outputs hold while pix_valid & !pix_ready, pix_ready ignored outside SCAN.
//
// Ports: clk, reset (sync, active-high), frame_tick, x0..y2 (signed physics units, +y up),
//        pix_ready/pix_valid handshake with pix_row (0 = top), pix_col (0 = left), pix_on,
//        frame_done (one-cycle pulse), busy (high outside IDLE).
// Build option: define PARTICLE_RASTER_HALO_EN to light the four orthogonal neighbours of each particle cell.
module particle_raster #(
    parameter int GRID_BITS   = 4,
    parameter int COORD_SHIFT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic signed [15:0]    x0,
    input  logic signed [15:0]    y0,
    input  logic signed [15:0]    x1,
    input  logic signed [15:0]    y1,
    input  logic signed [15:0]    x2,
    input  logic signed [15:0]    y2,
    input  logic                  pix_ready,
    output logic                  pix_valid,
    output logic [GRID_BITS-1:0]  pix_row,
    output logic [GRID_BITS-1:0]  pix_col,
    output logic                  pix_on,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int SPAN_BITS = GRID_BITS + COORD_SHIFT;
    localparam logic [GRID_BITS-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, LATCH, SCAN, DONE} state_t;
    state_t state;

    // Clamp to [0, 2^SPAN_BITS-1] and drop the sub-cell bits in one step:
    // anything above the span lands in the last cell.
    function automatic logic [GRID_BITS-1:0] to_cell(input logic signed [15:0] v);
        if (v[15])
            return '0;
        else if (($unsigned(v) >> SPAN_BITS) != 16'd0)
            return '1;
        else
            return v[SPAN_BITS-1:COORD_SHIFT];
    endfunction

    // Distances are taken in int so neighbours never wrap across grid edges.
    function automatic logic cell_hit(input logic [GRID_BITS-1:0] r, input logic [GRID_BITS-1:0] c,
                                      input logic [GRID_BITS-1:0] pr, input logic [GRID_BITS-1:0] pc);
        int dr;
        int dc;
        dr = int'(r) - int'(pr);
        dc = int'(c) - int'(pc);
`ifdef PARTICLE_RASTER_HALO_EN
        if (dr < 0) dr = -dr;
        if (dc < 0) dc = -dc;
        return (dr + dc) <= 1;
`else
        return (dr == 0) && (dc == 0);
`endif
    endfunction

    logic [GRID_BITS-1:0] snap_r [3];
    logic [GRID_BITS-1:0] snap_c [3];
    logic [GRID_BITS-1:0] cell_r [3];
    logic [GRID_BITS-1:0] cell_c [3];
    logic [GRID_BITS-1:0] src_r  [3];
    logic [GRID_BITS-1:0] src_c  [3];
    logic [GRID_BITS-1:0] next_row, next_col, tgt_row, tgt_col;
    logic                 next_on;

    always_comb begin
        // +y is up in physics space, row 0 is the top of the display.
        snap_c[0] = to_cell(x0);
        snap_r[0] = ~to_cell(y0);
        snap_c[1] = to_cell(x1);
        snap_r[1] = ~to_cell(y1);
        snap_c[2] = to_cell(x2);
        snap_r[2] = ~to_cell(y2);

        next_col = pix_col + GRID_BITS'(1);
        next_row = (pix_col == LAST) ? pix_row + GRID_BITS'(1) : pix_row;

        // pix_on is registered alongside the coordinates, so it is computed for the
        // pixel about to be presented. In LATCH that is (0,0) using the fresh snapshot.
        if (state == LATCH) begin
            tgt_row = '0;
            tgt_col = '0;
            src_r   = snap_r;
            src_c   = snap_c;
        end else begin
            tgt_row = next_row;
            tgt_col = next_col;
            src_r   = cell_r;
            src_c   = cell_c;
        end

        next_on = 1'b0;
        for (int p = 0; p < 3; p++)
            next_on = next_on | cell_hit(tgt_row, tgt_col, src_r[p], src_c[p]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pix_valid  <= 1'b0;
            pix_row    <= '0;
            pix_col    <= '0;
            pix_on     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            for (int p = 0; p < 3; p++) begin
                cell_r[p] <= '0;
                cell_c[p] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (frame_tick) begin
                        state <= LATCH;
                        busy  <= 1'b1;
                    end
                end
                LATCH: begin
                    cell_r    <= snap_r;
                    cell_c    <= snap_c;
                    pix_row   <= '0;
                    pix_col   <= '0;
                    pix_on    <= next_on;
                    pix_valid <= 1'b1;
                    state     <= SCAN;
                end
                SCAN: begin
                    if (pix_ready) begin
                        if (pix_row == LAST && pix_col == LAST) begin
                            pix_valid  <= 1'b0;
                            pix_on     <= 1'b0;
                            pix_row    <= '0;
                            pix_col    <= '0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            pix_row <= next_row;
                            pix_col <= next_col;
                            pix_on  <= next_on;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_particle_raster.sv
module tb_particle_raster;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_tick = 1'b0;
    logic signed [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic              pix_ready = 1'b1;
    logic              pix_valid;
    logic [3:0]        pix_row;
    logic [3:0]        pix_col;
    logic              pix_on;
    logic              frame_done;
    logic              busy;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Results gathered by capture_frame.
    int           beats, order_err, stall_err, first_valid_n, done_n, done_cnt, valid_after_done;
    logic [255:0] obs_map;
    logic [255:0] exp_map;

    particle_raster dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .pix_row    (pix_row),
        .pix_col    (pix_col),
        .pix_on     (pix_on),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic set_pos(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int ax2, input int ay2);
        x0 = 16'(ax0); y0 = 16'(ay0);
        x1 = 16'(ax1); y1 = 16'(ay1);
        x2 = 16'(ax2); y2 = 16'(ay2);
    endtask

    // Expected lit cell (grid coordinates), plus its in-grid neighbours when the halo is built in.
    task automatic mark(input int r, input int c);
        exp_map[r*16+c] = 1'b1;
`ifdef PARTICLE_RASTER_HALO_EN
        if (r > 0)  exp_map[(r-1)*16+c] = 1'b1;
        if (r < 15) exp_map[(r+1)*16+c] = 1'b1;
        if (c > 0)  exp_map[r*16+c-1]   = 1'b1;
        if (c < 15) exp_map[r*16+c+1]   = 1'b1;
`endif
    endtask

    // Pulses frame_tick, then observes every cycle at the negedge. Cycle n=1 is the cycle
    // after the edge that sampled the tick. disturb_n > 1 changes x0 and re-pulses the tick then.
    task automatic capture_frame(input bit rand_ready, input int disturb_n);
        int n;
        bit prev_stall;
        logic [3:0] prev_row, prev_col;
        logic prev_on;
        beats = 0; order_err = 0; stall_err = 0; first_valid_n = -1;
        done_n = -1; done_cnt = 0; valid_after_done = 0; obs_map = '0;
        prev_stall = 1'b0; prev_row = '0; prev_col = '0; prev_on = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (n == 1) frame_tick = 1'b0;
            if (n == disturb_n) begin
                x0 = 16'sd50;
                frame_tick = 1'b1;
            end
            if (n == disturb_n + 1 && n > 1) frame_tick = 1'b0;
            pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && (pix_valid !== 1'b1 || pix_row !== prev_row ||
                               pix_col !== prev_col || pix_on !== prev_on))
                stall_err++;
            if (pix_valid === 1'b1) begin
                if (first_valid_n < 0) first_valid_n = n;
                if (done_n >= 0) valid_after_done++;
                if (pix_ready) begin
                    if (beats >= 256 || {pix_row, pix_col} !== 8'(beats))
                        order_err++;
                    else
                        obs_map[beats] = pix_on;
                    beats++;
                end
            end
            prev_stall = (pix_valid === 1'b1) && !pix_ready;
            prev_row = pix_row;
            prev_col = pix_col;
            prev_on  = pix_on;
            if (frame_done === 1'b1) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
            end
            if (done_n >= 0 && n >= done_n + 5) break;
        end
        frame_tick = 1'b0;
        pix_ready  = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        frame_tick = 1'b1;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({pix_valid, pix_row, pix_col, pix_on, frame_done, busy} !== 12'h0) begin
            miss_cnt++;
            $display("FAIL reset_held: outputs=%h expected 000", {pix_valid, pix_row, pix_col, pix_on, frame_done, busy});
        end
        frame_tick = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vec_cnt++;
            if ({pix_valid, pix_row, pix_col, pix_on, frame_done, busy} !== 12'h0) begin
                miss_cnt++;
                $display("FAIL reset_idle[%0d]: outputs=%h expected 000", i, {pix_valid, pix_row, pix_col, pix_on, frame_done, busy});
            end
        end
    endtask

    task automatic test_basic();
        set_pos(128, 128, 0, 0, 0, 0);
        exp_map = '0;
        mark(7, 8);
        mark(15, 0);
        capture_frame(1'b0, 0);
        vec_cnt++; if (beats !== 256) begin miss_cnt++; $display("FAIL basic_beats: got %0d expected 256", beats); end
        vec_cnt++; if (order_err !== 0) begin miss_cnt++; $display("FAIL basic_order: got %0d errors expected 0", order_err); end
        vec_cnt++; if (first_valid_n !== 2) begin miss_cnt++; $display("FAIL basic_first_valid: cycle %0d expected 2", first_valid_n); end
        vec_cnt++; if (done_n !== 258) begin miss_cnt++; $display("FAIL basic_done_time: cycle %0d expected 258", done_n); end
        vec_cnt++; if (done_cnt !== 1) begin miss_cnt++; $display("FAIL basic_done_width: %0d cycles expected 1", done_cnt); end
        vec_cnt++; if (obs_map !== exp_map) begin miss_cnt++; $display("FAIL basic_map: got %h expected %h", obs_map, exp_map); end
        vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_clamp();
        set_pos(-5, 300, 255, 0, 4000, -1);
        exp_map = '0;
        mark(0, 0);
        mark(15, 15);
        capture_frame(1'b0, 0);
        vec_cnt++; if (beats !== 256) begin miss_cnt++; $display("FAIL clamp_beats: got %0d expected 256", beats); end
        vec_cnt++; if (obs_map !== exp_map) begin miss_cnt++; $display("FAIL clamp_map: got %h expected %h", obs_map, exp_map); end
        vec_cnt++; if (done_n !== 258) begin miss_cnt++; $display("FAIL clamp_done_time: cycle %0d expected 258", done_n); end
    endtask

    task automatic test_backpressure();
        set_pos(128, 128, 0, 0, 0, 0);
        exp_map = '0;
        mark(7, 8);
        mark(15, 0);
        capture_frame(1'b1, 0);
        vec_cnt++; if (beats !== 256) begin miss_cnt++; $display("FAIL bp_beats: got %0d expected 256", beats); end
        vec_cnt++; if (order_err !== 0) begin miss_cnt++; $display("FAIL bp_order: got %0d errors expected 0", order_err); end
        vec_cnt++; if (stall_err !== 0) begin miss_cnt++; $display("FAIL bp_stall_stable: got %0d errors expected 0", stall_err); end
        vec_cnt++; if (obs_map !== exp_map) begin miss_cnt++; $display("FAIL bp_map: got %h expected %h", obs_map, exp_map); end
        vec_cnt++; if (done_cnt !== 1) begin miss_cnt++; $display("FAIL bp_done_width: %0d cycles expected 1", done_cnt); end
    endtask

    task automatic test_mid_frame();
        set_pos(128, 128, 0, 0, 0, 0);
        exp_map = '0;
        mark(7, 8);
        mark(15, 0);
        capture_frame(1'b0, 100);
        vec_cnt++; if (obs_map !== exp_map) begin miss_cnt++; $display("FAIL mid_map: got %h expected %h", obs_map, exp_map); end
        vec_cnt++; if (done_n !== 258) begin miss_cnt++; $display("FAIL mid_done_time: cycle %0d expected 258", done_n); end
        vec_cnt++; if (valid_after_done !== 0) begin miss_cnt++; $display("FAIL mid_second_frame: %0d valid beats after done expected 0", valid_after_done); end
        vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL mid_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        int dcnt;
        int vcnt;
        bit reached;
        set_pos(128, 128, 0, 0, 0, 0);
        pix_ready = 1'b1;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        reached = 1'b0;
        n = 0;
        while (!reached && n < 400) begin
            @(negedge clk);
            n++;
            if (pix_valid === 1'b1 && pix_row === 4'd6 && pix_col === 4'd4) reached = 1'b1;
        end
        vec_cnt++; if (!reached) begin miss_cnt++; $display("FAIL rstmid_reach: pixel 100 not seen within %0d cycles", n); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vec_cnt++; if (pix_valid !== 1'b0) begin miss_cnt++; $display("FAIL rstmid_valid: got %b expected 0", pix_valid); end
        vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        dcnt = 0;
        vcnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0) dcnt++;
            if (pix_valid !== 1'b0) vcnt++;
        end
        vec_cnt++; if (dcnt !== 0) begin miss_cnt++; $display("FAIL rstmid_done: %0d frame_done cycles expected 0", dcnt); end
        vec_cnt++; if (vcnt !== 0) begin miss_cnt++; $display("FAIL rstmid_no_resume: %0d valid cycles expected 0", vcnt); end
    endtask

    task automatic test_back_to_back();
        int n;
        bit seen;
        set_pos(128, 128, 0, 0, 0, 0);
        pix_ready = 1'b1;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) seen = 1'b1;
        end
        vec_cnt++; if (!seen) begin miss_cnt++; $display("FAIL b2b_first_done: not seen within %0d cycles", n); end
        // Tick during the DONE cycle: must be dropped.
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL b2b_tick_on_done: busy=%b expected 0", busy); end
        // Tick in the first IDLE cycle: accepted.
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL b2b_tick_after_idle: busy=%b expected 1", busy); end
        @(negedge clk);
        vec_cnt++; if (pix_valid !== 1'b1 || pix_row !== 4'd0 || pix_col !== 4'd0) begin
            miss_cnt++;
            $display("FAIL b2b_first_pixel: valid=%b row=%0d col=%0d expected 1,0,0", pix_valid, pix_row, pix_col);
        end
        seen = 1'b0;
        n = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) seen = 1'b1;
        end
        vec_cnt++; if (n !== 256) begin miss_cnt++; $display("FAIL b2b_second_done: after %0d cycles expected 256", n); end
        repeat (2) @(negedge clk);
    endtask

`ifdef PARTICLE_RASTER_HALO_EN
    task automatic test_halo();
        set_pos(0, 0, 128, 128, 128, 128);
        exp_map = '0;
        exp_map[15*16+0] = 1'b1; exp_map[14*16+0] = 1'b1; exp_map[15*16+1] = 1'b1;
        exp_map[7*16+8]  = 1'b1; exp_map[6*16+8]  = 1'b1; exp_map[8*16+8]  = 1'b1;
        exp_map[7*16+7]  = 1'b1; exp_map[7*16+9]  = 1'b1;
        capture_frame(1'b0, 0);
        vec_cnt++; if (obs_map !== exp_map) begin miss_cnt++; $display("FAIL halo_map: got %h expected %h", obs_map, exp_map); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_backpressure();
        test_mid_frame();
        test_reset_mid();
        test_back_to_back();
`ifdef PARTICLE_RASTER_HALO_EN
        test_halo();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
